// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus between the fetch unit and instruction memory.
//   Mem_Req    master -> slave  request valid
//   Mem_Addr   master -> slave  fetch address
//   Mem_Ready  slave  -> master word returned this cycle
//   Mem_Data   slave  -> master instruction word
// The fetch unit is the master. Memory models and testbenches use the slave side.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              Mem_Req;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Ready;
  logic [DATA_W-1:0] Mem_Data;

  modport master (
    output Mem_Req,
    output Mem_Addr,
    input  Mem_Ready,
    input  Mem_Data
  );

  modport slave (
    input  Mem_Req,
    input  Mem_Addr,
    output Mem_Ready,
    output Mem_Data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. It combines the fetch-address counter (PC) and the
// instruction register (IR) in one block.
// It issues one request at a time on the memory bus and captures the returned word.
// It decodes the Op/Rs/Rt/Addr_Imm fields from that word.
// It also handles branch/jump redirect, a stall hold and a sticky memory-timeout trap.
// Ports:
//   Clk, Reset          clock (rising edge) and asynchronous active-high reset
//   Fetch_En            control unit allows a new fetch
//   Stall               hold IR/PC and block a new request
//   Redirect/_Addr      load the fetch address with a branch/jump target
//   mem                 memory request bus (master side)
//   IR, Op, Rs, Rt,
//   Addr_Imm            captured instruction and its decoded fields
//   PC                  address of the instruction held in IR
//   Instr_Valid         one-cycle pulse after a new IR capture
//   Timeout             sticky trap: memory did not answer within MAX_WAIT cycles
module fetch_unit #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RESET_VECTOR = 0,
  parameter int PC_STEP      = 4,
  parameter int MAX_WAIT     = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Fetch_En,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_Addr,
  fetch_unit_if.master      mem,
  output logic [DATA_W-1:0] IR,
  output logic [5:0]        Op,
  output logic [4:0]        Rs,
  output logic [4:0]        Rt,
  output logic [15:0]       Addr_Imm,
  output logic [ADDR_W-1:0] PC,
  output logic              Instr_Valid,
  output logic              Timeout
);

  // The counter must be at least 1 bit wide, even when the timeout is disabled.
  localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0]    WAIT_LAST = WCW'(MAX_WAIT - 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] RST_PC    = ADDR_W'(RESET_VECTOR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [WCW-1:0]    wait_cnt;
  logic              accept;
  logic              redirect_take;
  logic              timeout_hit;
  logic              mem_req;

  // Qualifying events of the current cycle. A redirect discards any word that arrives in the same cycle.
  always_comb begin
    accept        = (state == REQ) && mem.Mem_Ready && !Redirect;
    redirect_take = Redirect && (state != ERR);
    timeout_hit   = (state == REQ) && !mem.Mem_Ready && (MAX_WAIT != 0) &&
                    (wait_cnt == WAIT_LAST);
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (Fetch_En && !Stall) begin
          next_state = REQ;
        end else begin
          next_state = IDLE;
        end
      end
      REQ: begin
        if (accept) begin
          next_state = HOLD;
        end else if (timeout_hit) begin
          next_state = ERR;
        end else begin
          next_state = REQ;
        end
      end
      HOLD: begin
        if (Stall) begin
          next_state = HOLD;
        end else if (Fetch_En) begin
          next_state = REQ;
        end else begin
          next_state = IDLE;
        end
      end
      ERR: begin
        next_state = ERR;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode. The request is a pure function of the state register.
  always_comb begin
    mem_req = 1'b0;
    case (state)
      REQ:     mem_req = 1'b1;
      default: mem_req = 1'b0;
    endcase
  end

  // Fetch address and wait counter. ERR freezes both, because redirect_take excludes ERR.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fetch_pc <= RST_PC;
      wait_cnt <= '0;
    end else if (redirect_take) begin
      fetch_pc <= Redirect_Addr;
      wait_cnt <= '0;
    end else if (accept) begin
      fetch_pc <= fetch_pc + STEP;
      wait_cnt <= '0;
    end else if ((state == REQ) && !mem.Mem_Ready) begin
      wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  // Instruction capture, valid pulse and sticky trap flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      IR          <= '0;
      PC          <= '0;
      Instr_Valid <= 1'b0;
      Timeout     <= 1'b0;
    end else begin
      Instr_Valid <= accept;
      if (accept) begin
        IR <= mem.Mem_Data;
        PC <= fetch_pc;
      end
      if (timeout_hit) begin
        Timeout <= 1'b1;
      end
    end
  end

  assign mem.Mem_Req  = mem_req;
  assign mem.Mem_Addr = fetch_pc;
  assign Op           = IR[31:26];
  assign Rs           = IR[25:21];
  assign Rt           = IR[20:16];
  assign Addr_Imm     = IR[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. It uses a 32-bit instance (MAX_WAIT=15) and
// an 8-bit-address instance with the timeout disabled.
module tb_fetch_unit;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  // 32-bit instance
  logic        fetch_en;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [31:0] ir;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] addr_imm;
  logic [31:0] pc;
  logic        instr_valid;
  logic        timeout;

  // 8-bit instance
  logic        fetch_en8;
  logic        stall8;
  logic        redirect8;
  logic [7:0]  redirect_addr8;
  logic [31:0] ir8;
  logic [5:0]  op8;
  logic [4:0]  rs8;
  logic [4:0]  rt8;
  logic [15:0] addr_imm8;
  logic [7:0]  pc8;
  logic        instr_valid8;
  logic        timeout8;

  fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  fetch_unit_if #(.ADDR_W(8),  .DATA_W(32)) bus8 ();

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_VECTOR(0), .PC_STEP(4), .MAX_WAIT(15)) dut (
    .Clk(Clk), .Reset(Reset), .Fetch_En(fetch_en), .Stall(stall),
    .Redirect(redirect), .Redirect_Addr(redirect_addr), .mem(bus.master),
    .IR(ir), .Op(op), .Rs(rs), .Rt(rt), .Addr_Imm(addr_imm), .PC(pc),
    .Instr_Valid(instr_valid), .Timeout(timeout)
  );

  fetch_unit #(.ADDR_W(8), .DATA_W(32), .RESET_VECTOR(0), .PC_STEP(4), .MAX_WAIT(0)) dut8 (
    .Clk(Clk), .Reset(Reset), .Fetch_En(fetch_en8), .Stall(stall8),
    .Redirect(redirect8), .Redirect_Addr(redirect_addr8), .mem(bus8.master),
    .IR(ir8), .Op(op8), .Rs(rs8), .Rt(rt8), .Addr_Imm(addr_imm8), .PC(pc8),
    .Instr_Valid(instr_valid8), .Timeout(timeout8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    fetch_en = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
    bus.Mem_Ready = 1'b0; bus.Mem_Data = 32'h0;
    fetch_en8 = 1'b0; stall8 = 1'b0; redirect8 = 1'b0; redirect_addr8 = 8'h0;
    bus8.Mem_Ready = 1'b0; bus8.Mem_Data = 32'h0;
    tick();
    tick();
    check_val("rst_req",   {63'd0, bus.Mem_Req}, 64'd0);
    check_val("rst_addr",  {32'd0, bus.Mem_Addr}, 64'd0);
    check_val("rst_ir",    {32'd0, ir}, 64'd0);
    check_val("rst_pc",    {32'd0, pc}, 64'd0);
    check_val("rst_iv",    {63'd0, instr_valid}, 64'd0);
    check_val("rst_to",    {63'd0, timeout}, 64'd0);
    Reset = 1'b0;

    // 1. zero-wait fetch
    fetch_en = 1'b1;
    tick();
    check_val("t1_req",  {63'd0, bus.Mem_Req}, 64'd1);
    check_val("t1_addr", {32'd0, bus.Mem_Addr}, 64'd0);
    check_val("t1_iv0",  {63'd0, instr_valid}, 64'd0);
    bus.Mem_Ready = 1'b1; bus.Mem_Data = 32'h8C220004;
    tick();
    check_val("t1_ir",   {32'd0, ir}, 64'h8C220004);
    check_val("t1_op",   {58'd0, op}, 64'h23);
    check_val("t1_rs",   {59'd0, rs}, 64'd1);
    check_val("t1_rt",   {59'd0, rt}, 64'd2);
    check_val("t1_imm",  {48'd0, addr_imm}, 64'h4);
    check_val("t1_pc",   {32'd0, pc}, 64'd0);
    check_val("t1_iv",   {63'd0, instr_valid}, 64'd1);
    check_val("t1_naddr",{32'd0, bus.Mem_Addr}, 64'h4);
    check_val("t1_hreq", {63'd0, bus.Mem_Req}, 64'd0);
    bus.Mem_Ready = 1'b0;
    tick();
    check_val("t1_iv_pulse", {63'd0, instr_valid}, 64'd0);

    // 2. memory answers in the 4th REQ cycle
    for (int i = 0; i < 4; i++) begin
      check_val("t2_req",  {63'd0, bus.Mem_Req}, 64'd1);
      check_val("t2_addr", {32'd0, bus.Mem_Addr}, 64'h4);
      check_val("t2_iv",   {63'd0, instr_valid}, 64'd0);
      if (i == 3) begin
        bus.Mem_Ready = 1'b1; bus.Mem_Data = 32'h00430820;
      end
      tick();
    end
    check_val("t2_ir",   {32'd0, ir}, 64'h00430820);
    check_val("t2_rt",   {59'd0, rt}, 64'd3);
    check_val("t2_pc",   {32'd0, pc}, 64'h4);
    check_val("t2_iv",   {63'd0, instr_valid}, 64'd1);
    check_val("t2_naddr",{32'd0, bus.Mem_Addr}, 64'h8);
    bus.Mem_Ready = 1'b0;
    tick();
    check_val("t2_iv_pulse", {63'd0, instr_valid}, 64'd0);
    check_val("t2_req2", {63'd0, bus.Mem_Req}, 64'd1);

    // 3. Redirect in the same cycle as Mem_Ready discards the word
    bus.Mem_Ready = 1'b1; bus.Mem_Data = 32'hFFFFFFFF;
    redirect = 1'b1; redirect_addr = 32'h40;
    tick();
    check_val("t3_ir",   {32'd0, ir}, 64'h00430820);
    check_val("t3_pc",   {32'd0, pc}, 64'h4);
    check_val("t3_iv",   {63'd0, instr_valid}, 64'd0);
    check_val("t3_req",  {63'd0, bus.Mem_Req}, 64'd1);
    check_val("t3_addr", {32'd0, bus.Mem_Addr}, 64'h40);
    redirect = 1'b0;
    bus.Mem_Data = 32'h10A60010;
    tick();
    check_val("t3_ir2",  {32'd0, ir}, 64'h10A60010);
    check_val("t3_op",   {58'd0, op}, 64'h04);
    check_val("t3_rs",   {59'd0, rs}, 64'd5);
    check_val("t3_rt",   {59'd0, rt}, 64'd6);
    check_val("t3_imm",  {48'd0, addr_imm}, 64'h10);
    check_val("t3_pc2",  {32'd0, pc}, 64'h40);
    check_val("t3_naddr",{32'd0, bus.Mem_Addr}, 64'h44);

    // 4. Stall held in HOLD; a redirect on the first stalled edge still moves the fetch address
    bus.Mem_Ready = 1'b0; stall = 1'b1;
    redirect = 1'b1; redirect_addr = 32'h80;
    for (int i = 0; i < 5; i++) begin
      tick();
      redirect = 1'b0;
      check_val("t4_req",  {63'd0, bus.Mem_Req}, 64'd0);
      check_val("t4_ir",   {32'd0, ir}, 64'h10A60010);
      check_val("t4_pc",   {32'd0, pc}, 64'h40);
      check_val("t4_iv",   {63'd0, instr_valid}, 64'd0);
      check_val("t4_addr", {32'd0, bus.Mem_Addr}, 64'h80);
    end
    stall = 1'b0;
    tick();
    check_val("t4_req_up", {63'd0, bus.Mem_Req}, 64'd1);
    check_val("t4_addr2",  {32'd0, bus.Mem_Addr}, 64'h80);
    // Dropping Fetch_En while in REQ must not abort the outstanding request.
    fetch_en = 1'b0;
    bus.Mem_Ready = 1'b1; bus.Mem_Data = 32'h20010005;
    tick();
    check_val("t4_op",   {58'd0, op}, 64'h08);
    check_val("t4_imm",  {48'd0, addr_imm}, 64'h5);
    check_val("t4_pc2",  {32'd0, pc}, 64'h80);
    check_val("t4_iv2",  {63'd0, instr_valid}, 64'd1);
    bus.Mem_Ready = 1'b0;
    tick();
    check_val("t4_idle", {63'd0, bus.Mem_Req}, 64'd0);
    // In IDLE, Stall blocks a new request.
    fetch_en = 1'b1; stall = 1'b1;
    tick();
    check_val("t4_stall_idle", {63'd0, bus.Mem_Req}, 64'd0);

    // 5. Memory never answers: expect 15 REQ cycles, then the trap
    stall = 1'b0;
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.Mem_Req) n++;
      tick();
    end
    check_val("t5_req_cycles", 64'(n), 64'd15);
    check_val("t5_to",   {63'd0, timeout}, 64'd1);
    check_val("t5_req",  {63'd0, bus.Mem_Req}, 64'd0);
    redirect = 1'b1; redirect_addr = 32'h99; bus.Mem_Ready = 1'b1;
    tick(); tick(); tick();
    check_val("t5_frz_req",  {63'd0, bus.Mem_Req}, 64'd0);
    check_val("t5_frz_addr", {32'd0, bus.Mem_Addr}, 64'h84);
    check_val("t5_frz_ir",   {32'd0, ir}, 64'h20010005);
    check_val("t5_frz_to",   {63'd0, timeout}, 64'd1);
    redirect = 1'b0; bus.Mem_Ready = 1'b0;
    // Asynchronous reset clears the trap before the next clock edge.
    #2;
    Reset = 1'b1;
    #1;
    check_val("t5_rst_to",   {63'd0, timeout}, 64'd0);
    check_val("t5_rst_addr", {32'd0, bus.Mem_Addr}, 64'd0);
    Reset = 1'b0;

    // 6a. Reset asserted between edges while in REQ, and again just after a capture
    tick();
    check_val("t6_req",  {63'd0, bus.Mem_Req}, 64'd1);
    #2;
    Reset = 1'b1;
    #1;
    check_val("t6_async_req", {63'd0, bus.Mem_Req}, 64'd0);
    Reset = 1'b0;
    tick();
    bus.Mem_Ready = 1'b1; bus.Mem_Data = 32'hDEADBEEF;
    tick();
    check_val("t6_iv",   {63'd0, instr_valid}, 64'd1);
    #2;
    Reset = 1'b1;
    #1;
    check_val("t6_async_iv", {63'd0, instr_valid}, 64'd0);
    check_val("t6_async_ir", {32'd0, ir}, 64'd0);
    Reset = 1'b0;
    fetch_en = 1'b0; bus.Mem_Ready = 1'b0;

    // 6b. 8-bit address wraps from 0xFC to 0x00
    redirect8 = 1'b1; redirect_addr8 = 8'hFC; fetch_en8 = 1'b1;
    tick();
    check_val("t6_8_req",  {63'd0, bus8.Mem_Req}, 64'd1);
    check_val("t6_8_addr", {56'd0, bus8.Mem_Addr}, 64'hFC);
    redirect8 = 1'b0;
    bus8.Mem_Ready = 1'b1; bus8.Mem_Data = 32'h12345678;
    tick();
    check_val("t6_8_pc",   {56'd0, pc8}, 64'hFC);
    check_val("t6_8_ir",   {32'd0, ir8}, 64'h12345678);
    check_val("t6_8_wrap", {56'd0, bus8.Mem_Addr}, 64'h00);
    bus8.Mem_Ready = 1'b0;
    // With MAX_WAIT=0 the timeout is disabled, so a long wait never traps.
    for (int i = 0; i < 25; i++) tick();
    check_val("t6_8_noto", {63'd0, timeout8}, 64'd0);
    check_val("t6_8_req2", {63'd0, bus8.Mem_Req}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
